// File: rtl/shift_pkg.sv
// Shared definitions for the multicycle shifter: op encodings,
// FSM state enum, stage counter constants and the stage-weight mux.
package shift_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  localparam int         NSTAGE     = 5;
  localparam logic [2:0] LAST_STAGE = 3'd4;

  localparam logic [4:0] W0 = 5'd16;
  localparam logic [4:0] W1 = 5'd8;
  localparam logic [4:0] W2 = 5'd4;
  localparam logic [4:0] W3 = 5'd2;
  localparam logic [4:0] W4 = 5'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_valid(input logic [2:0] op);
    return op <= OP_ROR;
  endfunction

  // Weight is one-hot, MSB stage first.
  function automatic logic [4:0] stage_weight(
    input logic [2:0] cnt
  );
    logic [4:0] w;
    w = '0;
    unique case (cnt)
      3'd0:    w = W0;
      3'd1:    w = W1;
      3'd2:    w = W2;
      3'd3:    w = W3;
      3'd4:    w = W4;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational shifter stage: applies a single power-of-two
// weight for sll/srl/sra/rol/ror, or passes data through.
// Ports: data_in, op, weight (one-hot), en (apply), data_out.
module shift_stage
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SH_W   = 5
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [2:0]        op,
  input  logic [SH_W-1:0]   weight,
  input  logic              en,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] rol_v;
  logic [DATA_W-1:0] ror_v;
  int                back;

  assign back  = DATA_W - int'(weight);
  assign rol_v = (data_in << weight)
               | (data_in >> back);
  assign ror_v = (data_in >> weight)
               | (data_in << back);

  always_comb begin
    data_out = data_in;
    if (en) begin
      unique case (op)
        OP_SLL:  data_out = data_in << weight;
        OP_SRL:  data_out = data_in >> weight;
        OP_SRA:  data_out = $unsigned(
                   $signed(data_in) >>> weight);
        OP_ROL:  data_out = rol_v;
        OP_ROR:  data_out = ror_v;
        default: data_out = data_in;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_shifter.sv
// Multicycle barrel shifter: one shamt bit per cycle, MSB first.
// Ports: clock, reset (async active-low), ctrl_shift (start),
//   op, data_in, shamt -> data_result, data_resultRDY (1-cycle
//   pulse), data_busy (in RUN), data_exception (invalid op).
// Option: SHIFT_EARLY_OUT_EN ends RUN once remaining bits are 0.
module multicycle_shifter
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SH_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_shift,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SH_W-1:0]   shamt,
  output logic [DATA_W-1:0] data_result,
  output logic              data_resultRDY,
  output logic              data_busy,
  output logic              data_exception
);

  state_e            state_q;
  state_e            state_d;
  logic [2:0]        cnt_q;
  logic [2:0]        op_q;
  logic [SH_W-1:0]   shamt_q;
  logic [DATA_W-1:0] acc_q;
  logic              exc_q;

  logic              start;
  logic              last;
  logic              finish;
  logic [SH_W-1:0]   weight;
  logic              bit_en;
  logic [DATA_W-1:0] stage_out;

  assign weight = SH_W'(stage_weight(cnt_q));
  assign bit_en = |(shamt_q & weight);

`ifdef SHIFT_EARLY_OUT_EN
  // Done once no lower shamt bit is left to apply.
  assign finish = (cnt_q == LAST_STAGE)
               || ((shamt_q & (weight - 1'b1)) == '0);
`else
  assign finish = (cnt_q == LAST_STAGE);
`endif

  shift_stage #(
    .DATA_W (DATA_W),
    .SH_W   (SH_W)
  ) u_stage (
    .data_in  (acc_q),
    .op       (op_q),
    .weight   (weight),
    .en       (bit_en),
    .data_out (stage_out)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ctrl_shift) begin
          state_d = ST_RUN;
          start   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (finish) begin
          state_d = ST_DONE;
          last    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      op_q        <= '0;
      shamt_q     <= '0;
      acc_q       <= '0;
      exc_q       <= 1'b0;
      data_result <= '0;
    end else if (start) begin
      cnt_q   <= '0;
      op_q    <= op;
      shamt_q <= shamt;
      acc_q   <= data_in;
    end else if (state_q == ST_RUN) begin
      acc_q <= stage_out;
      cnt_q <= cnt_q + 3'd1;
      if (last) begin
        data_result <= stage_out;
        exc_q       <= !op_valid(op_q);
      end
    end
  end

  assign data_resultRDY = (state_q == ST_DONE);
  assign data_busy      = (state_q == ST_RUN);
  assign data_exception = (state_q == ST_DONE) && exc_q;

endmodule

// File: tb/tb_multicycle_shifter.sv
// Directed testbench for multicycle_shifter.
// Honours SHIFT_EARLY_OUT_EN when computing expected latency.
module tb_multicycle_shifter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_shift = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_busy;
  logic        data_exception;

  int total = 0;
  int bad   = 0;

  multicycle_shifter #(
    .DATA_W (32),
    .SH_W   (5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_shift     (ctrl_shift),
    .op             (op),
    .data_in        (data_in),
    .shamt          (shamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy),
    .data_exception (data_exception)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [4:0] s);
`ifdef SHIFT_EARLY_OUT_EN
    logic [4:0] m;
    for (int k = 1; k <= 5; k++) begin
      m = 5'h1f >> k;
      if ((s & m) == 5'd0) return k;
    end
    return 5;
`else
    return 5;
`endif
  endfunction

  task automatic launch(input logic [2:0] o,
                        input logic [31:0] d,
                        input logic [4:0] s);
    @(negedge clock);
    op = o; data_in = d; shamt = s;
    ctrl_shift = 1'b1;
    @(posedge clock); #1;
    ctrl_shift = 1'b0;
  endtask

  task automatic wait_rdy(input int n0, output int n);
    n = n0;
    while (!data_resultRDY && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [2:0] o,
                       input logic [31:0] d,
                       input logic [4:0] s,
                       input logic [31:0] res,
                       input logic exc);
    int n;
    launch(o, d, s);
    check({tag, "_busy"}, 32'(data_busy), 32'd1);
    wait_rdy(0, n);
    check({tag, "_lat"}, n, exp_lat(s));
    check({tag, "_res"}, data_result, res);
    check({tag, "_exc"}, 32'(data_exception), 32'(exc));
    @(posedge clock); #1;
    check({tag, "_rdy_off"}, 32'(data_resultRDY), 32'd0);
    check({tag, "_exc_off"}, 32'(data_exception), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;

    repeat (3) @(posedge clock);
    #1;
    check("rst_res",  data_result, 32'h0);
    check("rst_rdy",  32'(data_resultRDY), 32'd0);
    check("rst_busy", 32'(data_busy), 32'd0);
    check("rst_exc",  32'(data_exception), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    do_op("sra31", 3'b010, 32'h8000_0000, 5'd31,
          32'hFFFF_FFFF, 1'b0);
    do_op("ror1", 3'b100, 32'h0000_0001, 5'd1,
          32'h8000_0000, 1'b0);
    do_op("rol4", 3'b011, 32'h8000_0001, 5'd4,
          32'h0000_0018, 1'b0);
    do_op("sra_pos", 3'b010, 32'h4000_0000, 5'd4,
          32'h0400_0000, 1'b0);
    do_op("sll31", 3'b000, 32'h0000_0001, 5'd31,
          32'h8000_0000, 1'b0);
    do_op("srl16", 3'b001, 32'hFFFF_FFFF, 5'd16,
          32'h0000_FFFF, 1'b0);
    do_op("sll0", 3'b000, 32'hA5A5_A5A5, 5'd0,
          32'hA5A5_A5A5, 1'b0);
    do_op("ror0", 3'b100, 32'h1234_5678, 5'd0,
          32'h1234_5678, 1'b0);
    do_op("bad_op", 3'b111, 32'h1234_5678, 5'd9,
          32'h1234_5678, 1'b1);
    do_op("bad_op5", 3'b101, 32'hCAFE_F00D, 5'd3,
          32'hCAFE_F00D, 1'b1);

    // Start pulsed again mid-RUN must be ignored.
    launch(3'b001, 32'hF000_0000, 5'd4);
    @(posedge clock); #1;
    ctrl_shift = 1'b1;
    op = 3'b000; data_in = 32'h1; shamt = 5'd1;
    @(posedge clock); #1;
    ctrl_shift = 1'b0;
    wait_rdy(2, n);
    check("srl_mid_lat", n, exp_lat(5'd4));
    check("srl_mid_res", data_result, 32'h0F00_0000);
    pulses = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (data_resultRDY) pulses++;
    end
    check("srl_mid_pulses", pulses, 0);
    check("srl_mid_idle", 32'(data_busy), 32'd0);

    // Operand changes during RUN have no effect.
    launch(3'b000, 32'h0000_0001, 5'd3);
    op = 3'b010; data_in = 32'hFFFF_FFFF;
    shamt = 5'd31;
    wait_rdy(0, n);
    check("hold_lat", n, exp_lat(5'd3));
    check("hold_res", data_result, 32'h0000_0008);

    // Reset two edges into RUN.
    launch(3'b010, 32'h8000_0000, 5'd31);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("mid_rst_res",  data_result, 32'h0);
    check("mid_rst_busy", 32'(data_busy), 32'd0);
    check("mid_rst_rdy",  32'(data_resultRDY), 32'd0);
    check("mid_rst_exc",  32'(data_exception), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (data_resultRDY || data_busy) pulses++;
    end
    check("mid_rst_quiet", pulses, 0);
    do_op("post_rst_sll", 3'b000, 32'h0000_0001, 5'd3,
          32'h0000_0008, 1'b0);

    // Back-to-back: start asserted in the DONE cycle.
    launch(3'b000, 32'h0000_0003, 5'd2);
    wait_rdy(0, n);
    check("b2b1_lat", n, exp_lat(5'd2));
    check("b2b1_res", data_result, 32'h0000_000C);
    op = 3'b100; data_in = 32'h0000_000F;
    shamt = 5'd4;
    ctrl_shift = 1'b1;
    @(posedge clock); #1;
    ctrl_shift = 1'b0;
    check("b2b2_busy", 32'(data_busy), 32'd1);
    check("b2b2_rdy",  32'(data_resultRDY), 32'd0);
    wait_rdy(0, n);
    check("b2b2_lat", n, exp_lat(5'd4));
    check("b2b2_res", data_result, 32'hF000_0000);
    @(posedge clock); #1;
    check("b2b2_rdy_off", 32'(data_resultRDY), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
